// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the diad pipeline.
// One in-flight response is parked in a skid register so a stall release costs no bubble.
module fetch_stage #(
  parameter int ADDR_W = 24,
  parameter int INSTR_W = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic               iw_stall,
  input  logic               iw_flush,
  input  logic [ADDR_W-1:0]  iw_branch_pc,
  output logic               ow_imem_en,
  output logic [ADDR_W-1:0]  ow_imem_addr,
  input  logic [INSTR_W-1:0] iw_imem_data,
  output logic               ow_ifid_valid,
  output logic [ADDR_W-1:0]  ow_ifid_pc,
  output logic [INSTR_W-1:0] ow_ifid_instr
);

  logic               r_run;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_req_vld;
  logic [ADDR_W-1:0]  r_req_pc;
  logic               r_skid_vld;
  logic [ADDR_W-1:0]  r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;

  // A flush always issues its redirect, even against a stall.
  always_comb begin
    ow_imem_en   = r_run & (iw_flush | ~iw_stall);
    ow_imem_addr = iw_flush ? iw_branch_pc : r_pc;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_run         <= 1'b0;
      r_pc          <= RESET_PC;
      r_req_vld     <= 1'b0;
      r_req_pc      <= '0;
      r_skid_vld    <= 1'b0;
      r_skid_pc     <= '0;
      r_skid_instr  <= '0;
      ow_ifid_valid <= 1'b0;
      ow_ifid_pc    <= '0;
      ow_ifid_instr <= '0;
    end else begin
      r_run     <= 1'b1;
      r_req_vld <= ow_imem_en;
      r_req_pc  <= ow_imem_addr;
      if (ow_imem_en) begin
        r_pc <= ow_imem_addr + 1'b1;
      end

      if (iw_flush) begin
        // Returning data belongs to the wrong path and is dropped.
        ow_ifid_valid <= 1'b0;
        r_skid_vld    <= 1'b0;
      end else if (iw_stall) begin
        if (r_req_vld) begin
          r_skid_vld   <= 1'b1;
          r_skid_pc    <= r_req_pc;
          r_skid_instr <= iw_imem_data;
        end
      end else if (r_skid_vld) begin
        ow_ifid_valid <= 1'b1;
        ow_ifid_pc    <= r_skid_pc;
        ow_ifid_instr <= r_skid_instr;
        r_skid_vld    <= 1'b0;
      end else begin
        ow_ifid_valid <= r_req_vld;
        if (r_req_vld) begin
          ow_ifid_pc    <= r_req_pc;
          ow_ifid_instr <= iw_imem_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based fetch model checked every cycle, plus directed literal checks.
module tb_fetch_stage;

  localparam logic [23:0] RST_PC = 24'h000010;
  localparam logic [23:0] PAT    = 24'hA5A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [23:0] bpc;
  logic        imem_en;
  logic [23:0] imem_addr;
  logic [23:0] imem_data = '0;
  logic        ifid_valid;
  logic [23:0] ifid_pc;
  logic [23:0] ifid_instr;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  fetch_stage #(.ADDR_W(24), .INSTR_W(24), .RESET_PC(RST_PC)) dut (
    .iw_clk(clk),
    .iw_rst_n(rst_n),
    .iw_stall(stall),
    .iw_flush(flush),
    .iw_branch_pc(bpc),
    .ow_imem_en(imem_en),
    .ow_imem_addr(imem_addr),
    .iw_imem_data(imem_data),
    .ow_ifid_valid(ifid_valid),
    .ow_ifid_pc(ifid_pc),
    .ow_ifid_instr(ifid_instr)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: mem[a] = a ^ PAT.
  always @(posedge clk) begin
    if (imem_en) imem_data <= imem_addr ^ PAT;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: fetched instructions wait in program order in a queue until IF/ID takes them.
  logic        m_run = 1'b0;
  logic [23:0] m_pc = RST_PC;
  logic [23:0] pend[$];
  logic        e_valid = 1'b0;
  logic [23:0] e_pc = '0;
  logic [23:0] e_instr = '0;

  always @(posedge clk or negedge rst_n) begin
    logic        en;
    logic [23:0] addr;
    logic [23:0] p;
    if (!rst_n) begin
      m_run = 1'b0;
      m_pc = RST_PC;
      pend.delete();
      e_valid = 1'b0;
      e_pc = '0;
      e_instr = '0;
    end else begin
      en   = m_run && (flush || !stall);
      addr = flush ? bpc : m_pc;
      if (flush) begin
        pend.delete();
        e_valid = 1'b0;
      end else if (!stall) begin
        if (pend.size() > 0) begin
          p = pend.pop_front();
          e_valid = 1'b1;
          e_pc = p;
          e_instr = p ^ PAT;
        end else begin
          e_valid = 1'b0;
        end
      end
      if (en) begin
        pend.push_back(addr);
        m_pc = addr + 24'd1;
      end
      m_run = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic        x_en;
    logic [23:0] x_addr;
    if (chk_on) begin
      x_en   = rst_n && m_run && (flush || !stall);
      x_addr = flush ? bpc : m_pc;
      chk("m_ifid_valid", 32'(ifid_valid), 32'(e_valid));
      chk("m_ifid_pc", 32'(ifid_pc), 32'(e_pc));
      chk("m_ifid_instr", 32'(ifid_instr), 32'(e_instr));
      chk("m_imem_en", 32'(imem_en), 32'(x_en));
      if (x_en) chk("m_imem_addr", 32'(imem_addr), 32'(x_addr));
      if (pend.size() > 2) chk("m_pending_depth", 32'(pend.size()), 32'd2);
    end
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    bpc   = '0;
    repeat (3) tick();
    chk_on = 1'b1;
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_en", 32'(imem_en), 32'd0);
    chk("rst_pc", 32'(ifid_pc), 32'd0);
    chk("rst_instr", 32'(ifid_instr), 32'd0);

    // Straight-line fetch from RESET_PC.
    rst_n = 1'b1;
    tick();
    chk("first_en", 32'(imem_en), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'h10);
    chk("first_valid_early", 32'(ifid_valid), 32'd0);
    tick();
    chk("second_valid_early", 32'(ifid_valid), 32'd0);
    tick();
    chk("first_valid", 32'(ifid_valid), 32'd1);
    chk("first_pc", 32'(ifid_pc), 32'h10);
    chk("first_instr", 32'(ifid_instr), 32'hA5A5B5);
    tick();
    chk("second_pc", 32'(ifid_pc), 32'h11);
    chk("second_instr", 32'(ifid_instr), 32'hA5A5B4);
    repeat (3) tick();
    chk("pre_stall_pc", 32'(ifid_pc), 32'h14);

    // Stall 2 cycles at PC 0x14.
    stall = 1'b1;
    #1 chk("stall_en", 32'(imem_en), 32'd0);
    tick();
    chk("stall_hold1", 32'(ifid_pc), 32'h14);
    tick();
    chk("stall_hold2", 32'(ifid_pc), 32'h14);
    stall = 1'b0;
    tick();
    chk("post_stall_pc1", 32'(ifid_pc), 32'h15);
    chk("post_stall_instr1", 32'(ifid_instr), 32'hA5A5B0);
    tick();
    chk("post_stall_pc2", 32'(ifid_pc), 32'h16);

    // Stall 1, then stall 3 (model covers the sequence).
    repeat (2) tick();
    stall = 1'b1;
    tick();
    stall = 1'b0;
    repeat (3) tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    repeat (3) tick();

    // Flush to 0x200.
    flush = 1'b1;
    bpc   = 24'h000200;
    #1;
    chk("flush_en", 32'(imem_en), 32'd1);
    chk("flush_addr", 32'(imem_addr), 32'h200);
    tick();
    flush = 1'b0;
    chk("flush_bubble", 32'(ifid_valid), 32'd0);
    tick();
    chk("flush_valid", 32'(ifid_valid), 32'd1);
    chk("flush_pc", 32'(ifid_pc), 32'h200);
    chk("flush_instr", 32'(ifid_instr), 32'hA5A7A5);
    tick();
    chk("flush_pc_next", 32'(ifid_pc), 32'h201);

    // Flush in the 2nd cycle of a 3-cycle stall while the skid holds an entry.
    repeat (2) tick();
    stall = 1'b1;
    tick();
    flush = 1'b1;
    bpc   = 24'h000040;
    tick();
    flush = 1'b0;
    tick();
    stall = 1'b0;
    chk("skid_flush_bubble", 32'(ifid_valid), 32'd0);
    tick();
    chk("skid_flush_valid", 32'(ifid_valid), 32'd1);
    chk("skid_flush_pc", 32'(ifid_pc), 32'h40);
    chk("skid_flush_instr", 32'(ifid_instr), 32'hA5A5E5);

    // Address wrap.
    repeat (2) tick();
    flush = 1'b1;
    bpc   = 24'hFFFFFE;
    tick();
    flush = 1'b0;
    tick();
    chk("wrap_pc0", 32'(ifid_pc), 32'hFFFFFE);
    chk("wrap_instr0", 32'(ifid_instr), 32'h5A5A5B);
    tick();
    chk("wrap_pc1", 32'(ifid_pc), 32'hFFFFFF);
    tick();
    chk("wrap_pc2", 32'(ifid_pc), 32'h000000);
    chk("wrap_instr2", 32'(ifid_instr), 32'hA5A5A5);

    // Asynchronous reset between edges, during a stall.
    tick();
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(ifid_valid), 32'd0);
    chk("async_en", 32'(imem_en), 32'd0);
    chk("async_pc", 32'(ifid_pc), 32'd0);
    tick();
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("resume_valid", 32'(ifid_valid), 32'd1);
    chk("resume_pc", 32'(ifid_pc), 32'h10);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
